sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of cycles to wait for mem_ready before a grant is abandoned; legal range 1..1023.
REQ-002 Port clk, input, 1: single clock for all logic.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port req_valid, input, 3: per-requester request; bit i held high until req_ack[i].
REQ-005 Port req_addr, input, 81: 3 x 27-bit byte addresses; requester i uses bits [27i+26:27i].
REQ-006 Port req_din, input, 96: 3 x 32-bit write data; requester i uses bits [32i+31:32i].
REQ-007 Port req_rnw, input, 3: per-requester direction; 1 is read, 0 is write.
REQ-008 Port req_be, input, 12: 3 x 4-bit byte enables; requester i uses bits [4i+3:4i].
REQ-009 Port req_ack, output, 3: one-cycle pulse when requester i's request is accepted.
REQ-010 Port req_done, output, 3: one-cycle pulse when requester i's access completes.
REQ-011 Port rd_data, output, 32: read data, valid in the req_done cycle.
REQ-012 Port mem_req, output, 1: one-cycle request pulse to the SDRAM channel.
REQ-013 Ports mem_addr (27), mem_din (32), mem_rnw (1) and mem_be (4), outputs: registered command fields, stable from the mem_req cycle until the grant ends.
REQ-014 Port mem_ready, input, 1: one-cycle completion pulse from the SDRAM channel.
REQ-015 Port mem_dout, input, 32: read data, valid with mem_ready.
REQ-016 Port timeout_err, output, 1: sticky flag set when a grant times out.

Function
REQ-017 The arbiter SHALL implement states IDLE, BUSY and DONE.
REQ-018 In IDLE with any req_valid bit high at cycle N, the arbiter SHALL select one requester g and, in cycle N+1, be in BUSY with mem_req=1, req_ack[g]=1 and mem_* loaded from requester g.
REQ-019 mem_req and req_ack SHALL be high for exactly one cycle per grant.
REQ-020 In BUSY, mem_ready at cycle M SHALL capture mem_dout into rd_data and move to DONE, with req_done[g]=1 in cycle M+1.
REQ-021 DONE SHALL last one cycle and then return to IDLE; the earliest next mem_req is therefore M+3.
REQ-022 rd_data SHALL hold its last value until the next capture; on a write grant rd_data is not updated.
REQ-023 mem_ready SHALL be ignored in IDLE and DONE.
REQ-024 mem_ready arriving in the same cycle as mem_req SHALL be ignored.
REQ-025 In BUSY, a 10-bit counter SHALL count from the mem_req cycle; when it reaches TIMEOUT_CYCLES without mem_ready, the arbiter SHALL set timeout_err, pulse req_done[g], leave rd_data unchanged and go to DONE.
REQ-026 req_valid changes during BUSY or DONE SHALL not affect the current grant.
REQ-027 A requester whose req_valid drops before it is acked SHALL simply not be granted.
REQ-028 At most one bit of req_ack and at most one bit of req_done SHALL be high in any cycle.

Reset
REQ-029 On reset the arbiter SHALL enter IDLE.
REQ-030 On reset req_ack, req_done, mem_req, mem_addr, mem_din, mem_rnw, mem_be, rd_data, timeout_err, the timeout counter and the priority pointer SHALL all be 0.
REQ-031 Reset asserted during BUSY SHALL abandon the grant with no req_done; a mem_ready arriving after reset SHALL be ignored.

Configuration
REQ-032 With macro SDRAM_ARBITER_RR_EN defined, selection SHALL be round-robin.
- A 2-bit pointer p (reset 0) gives priority order p, p+1, p+2 mod 3.
- After granting g, p SHALL become (g+1) mod 3.
REQ-033 Without SDRAM_ARBITER_RR_EN, selection SHALL be fixed priority 0 > 1 > 2, and the pointer is not implemented.

Verification
REQ-034 Single read: req_valid=001, addr0=0x0001000, rnw0=1; mem_ready with mem_dout=0xDEADBEEF three cycles after mem_req -> mem_addr=0x0001000, one req_ack[0] pulse, then req_done[0] and rd_data=0xDEADBEEF one cycle after mem_ready.
REQ-035 Write: requester 2, din=0x12345678, be=0011, rnw=0 -> mem_rnw=0, mem_be=0011, mem_din=0x12345678; req_done[2] follows mem_ready; rd_data unchanged.
REQ-036 Contention: req_valid=111 held continuously -> with RR_EN defined, grant order 0,1,2,0; without it, requester 0 is granted repeatedly; mem_req spacing is at least 3 cycles after each mem_ready.
REQ-037 Timeout: TIMEOUT_CYCLES=8, mem_ready never driven -> req_done pulses and timeout_err=1 at the 8th cycle after mem_req; the next request is then serviced normally.
REQ-038 Reset mid-grant: assert reset 2 cycles after mem_req, then pulse mem_ready after reset is released -> no req_done, all outputs 0, state IDLE.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-requester arbiter in front of a single SDRAM command channel.
// One grant at a time: IDLE selects a requester, BUSY waits for mem_ready or a
// timeout, DONE reports completion for one cycle before returning to IDLE.
// Optional feature: define SDRAM_ARBITER_RR_EN for round-robin selection; the
// default build uses fixed priority 0 > 1 > 2 and has no priority pointer.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [80:0] req_addr,
  input  logic [95:0] req_din,
  input  logic [2:0]  req_rnw,
  input  logic [11:0] req_be,
  output logic [2:0]  req_ack,
  output logic [2:0]  req_done,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic [26:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_rnw,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_dout,
  output logic        timeout_err
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 27;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned CW   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            mem_rnw_q, mem_rnw_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            timeout_err_q, timeout_err_d;

  logic            sel_found;
  logic [1:0]      sel_idx;
  logic [1:0]      sel_next;

`ifdef SDRAM_ARBITER_RR_EN
  logic [1:0]      ptr_q, ptr_d;
  logic [2:0]      cand_sum;
  logic [1:0]      cand;

  // Round-robin pick: scan p, p+1, p+2 (mod 3), first valid requester wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand_sum  = 3'd0;
    cand      = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand_sum = {1'b0, ptr_q} + 3'(k);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : 2'(cand_sum);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end
`else
  // Fixed priority pick: requester 0 beats 1 beats 2.
  always_comb begin
    sel_found = |req_valid;
    if (req_valid[0])      sel_idx = 2'd0;
    else if (req_valid[1]) sel_idx = 2'd1;
    else                   sel_idx = 2'd2;
  end
`endif

  // Index of the requester after the selected one, wrapping at 3.
  always_comb begin
    sel_next = (sel_idx == 2'd2) ? 2'd0 : 2'(sel_idx + 2'd1);
  end

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    mem_req_d     = 1'b0;
    req_ack_d     = '0;
    req_done_d    = '0;
    rd_data_d     = rd_data_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_rnw_d     = mem_rnw_q;
    mem_be_d      = mem_be_q;
    timeout_err_d = timeout_err_q;
`ifdef SDRAM_ARBITER_RR_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = BUSY;
          gnt_d      = sel_idx;
          mem_req_d  = 1'b1;
          req_ack_d  = NREQ'(1) << sel_idx;
          mem_addr_d = req_addr[int'(sel_idx)*AW +: AW];
          mem_din_d  = req_din[int'(sel_idx)*DW +: DW];
          mem_rnw_d  = req_rnw[sel_idx];
          mem_be_d   = req_be[int'(sel_idx)*BW +: BW];
          // Counter reads 1 in the mem_req cycle, so it hits the limit
          // exactly TIMEOUT_CYCLES-1 cycles later and done lands one after.
          cnt_d      = CW'(1);
`ifdef SDRAM_ARBITER_RR_EN
          ptr_d      = sel_next;
`endif
        end
      end
      BUSY: begin
        // A ready in the mem_req cycle belongs to no command of ours.
        if (mem_ready && !mem_req_q) begin
          if (mem_rnw_q) rd_data_d = mem_dout;
          req_done_d = NREQ'(1) << gnt_q;
          state_d    = DONE;
        end else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
          timeout_err_d = 1'b1;
          req_done_d    = NREQ'(1) << gnt_q;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= 2'd0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      req_ack_q     <= '0;
      req_done_q    <= '0;
      rd_data_q     <= '0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_rnw_q     <= 1'b0;
      mem_be_q      <= '0;
      timeout_err_q <= 1'b0;
`ifdef SDRAM_ARBITER_RR_EN
      ptr_q         <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      req_ack_q     <= req_ack_d;
      req_done_q    <= req_done_d;
      rd_data_q     <= rd_data_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_rnw_q     <= mem_rnw_d;
      mem_be_q      <= mem_be_d;
      timeout_err_q <= timeout_err_d;
`ifdef SDRAM_ARBITER_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign req_ack     = req_ack_q;
  assign req_done    = req_done_q;
  assign rd_data     = rd_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_rnw     = mem_rnw_q;
  assign mem_be      = mem_be_q;
  assign timeout_err = timeout_err_q;

endmodule
